// File: rtl/ram_fifo_ctrl.sv
// Synchronous FIFO controller for the 64x8 dual-port RAM, with a 2-entry output skid buffer.
// Optional: define FIFO_CTRL_STATS_EN to add the drop_cnt statistics port.
module ram_fifo_ctrl #(
    parameter int AW = 6,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          ram_we_en,
    output logic [AW-1:0] ram_we_addr,
    output logic [DW-1:0] ram_din,
    output logic          ram_rd_en,
    output logic [AW-1:0] ram_re_addr,
    input  logic [DW-1:0] ram_dout,
    output logic [AW:0]   level
`ifdef FIFO_CTRL_STATS_EN
    ,
    output logic [7:0]    drop_cnt
`endif
);

    // The RAM zeroes mem[we_addr] whenever we_en is low, so the write pointer
    // must always park on a free slot: one slot is sacrificed.
    localparam logic [AW-1:0] DEPTH = {AW{1'b1}};
    localparam logic [AW-1:0] ONE   = {{(AW-1){1'b0}}, 1'b1};
    localparam int            NBUF  = 2;

    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] ram_cnt_reg;
    logic [AW-1:0] ram_cnt_next;
    logic          inflight_reg;
    logic [1:0]    buf_cnt_reg;
    logic [1:0]    buf_cnt_next;
    logic [1:0]    buf_wr_idx;
    logic [DW-1:0] buf_reg   [NBUF];
    logic [DW-1:0] buf_next  [NBUF];
    logic [DW-1:0] shift_src [NBUF];
    logic [AW:0]   level_reg;
    logic [AW:0]   level_next;
    logic          wr;
    logic          pop;
    logic          push;
    logic [2:0]    occ_after;

    assign s_ready     = !rst && (ram_cnt_reg != DEPTH);
    assign wr          = s_valid && s_ready;
    assign ram_we_en   = wr;
    assign ram_we_addr = wr_ptr_reg;
    assign ram_din     = s_data;

    assign m_valid = (buf_cnt_reg != 2'd0);
    assign pop     = m_valid && m_ready;
    assign push    = inflight_reg;
    assign m_data  = buf_reg[0];
    assign level   = level_reg;

    // Only fetch when the buffer is guaranteed a free entry once the read lands.
    assign occ_after   = 3'(inflight_reg) + 3'(buf_cnt_reg) - 3'(pop);
    assign ram_rd_en   = !rst && (ram_cnt_reg != '0) && (occ_after < 3'd2);
    assign ram_re_addr = rd_ptr_reg;

    // Skid buffer: entry 0 is the head; a pop shifts down, a push lands after the survivors.
    assign buf_wr_idx = buf_cnt_reg - 2'(pop);

    genvar gi;
    generate
        for (gi = 0; gi < NBUF; gi++) begin : g_buf
            if (gi < NBUF - 1) begin : g_shift
                assign shift_src[gi] = buf_reg[gi+1];
            end else begin : g_last
                assign shift_src[gi] = buf_reg[gi];
            end
            assign buf_next[gi] = (push && (buf_wr_idx == 2'(gi))) ? ram_dout :
                                  pop                               ? shift_src[gi] :
                                                                      buf_reg[gi];
        end
    endgenerate

    always_comb begin
        ram_cnt_next = ram_cnt_reg;
        case ({wr, ram_rd_en})
            2'b10:   ram_cnt_next = ram_cnt_reg + ONE;
            2'b01:   ram_cnt_next = ram_cnt_reg - ONE;
            default: ram_cnt_next = ram_cnt_reg;
        endcase
        buf_cnt_next = buf_cnt_reg + 2'(push) - 2'(pop);
        level_next   = (AW+1)'(ram_cnt_next) + (AW+1)'(ram_rd_en) + (AW+1)'(buf_cnt_next);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            ram_cnt_reg  <= '0;
            inflight_reg <= 1'b0;
            buf_cnt_reg  <= '0;
            level_reg    <= '0;
            for (int i = 0; i < NBUF; i++) begin
                buf_reg[i] <= '0;
            end
        end else begin
            if (wr) begin
                wr_ptr_reg <= wr_ptr_reg + ONE;
            end
            if (ram_rd_en) begin
                rd_ptr_reg <= rd_ptr_reg + ONE;
            end
            ram_cnt_reg  <= ram_cnt_next;
            inflight_reg <= ram_rd_en;
            buf_cnt_reg  <= buf_cnt_next;
            level_reg    <= level_next;
            for (int i = 0; i < NBUF; i++) begin
                buf_reg[i] <= buf_next[i];
            end
        end
    end

`ifdef FIFO_CTRL_STATS_EN
    logic [7:0] drop_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_reg <= '0;
        end else if (s_valid && !s_ready && (drop_cnt_reg != 8'hFF)) begin
            drop_cnt_reg <= drop_cnt_reg + 8'd1;
        end
    end

    assign drop_cnt = drop_cnt_reg;
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with a behavioural model of the external 64x8 RAM.
// Define FIFO_CTRL_STATS_EN to also exercise the drop counter.
module tb_ram_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       ram_we_en;
    logic [5:0] ram_we_addr;
    logic [7:0] ram_din;
    logic       ram_rd_en;
    logic [5:0] ram_re_addr;
    logic [7:0] ram_dout;
    logic [6:0] level;
`ifdef FIFO_CTRL_STATS_EN
    logic [7:0] drop_cnt;
`endif

    always #5 clk = ~clk;

    ram_fifo_ctrl #(.AW(6), .DW(8)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .ram_we_en(ram_we_en), .ram_we_addr(ram_we_addr), .ram_din(ram_din),
        .ram_rd_en(ram_rd_en), .ram_re_addr(ram_re_addr), .ram_dout(ram_dout),
        .level(level)
`ifdef FIFO_CTRL_STATS_EN
        , .drop_cnt(drop_cnt)
`endif
    );

    // External RAM: registered read, zero-write to the parked address when idle.
    logic [7:0] mem [64];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
            ram_dout <= 8'h00;
        end else begin
            if (ram_rd_en) ram_dout <= mem[ram_re_addr];
            mem[ram_we_addr] <= ram_we_en ? ram_din : 8'h00;
        end
    end

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         acc_cnt = 0;
    int         pop_cnt = 0;
    int         first_acc_cyc = -1;
    int         first_valid_cyc = -1;
    bit         last_acc = 1'b0;
    bit         stall_prev = 1'b0;
    logic [7:0] held_data = 8'h00;
    logic [7:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Settle just after the negedge drive, then account for this cycle's handshakes.
    task automatic sample();
        #1;
        if (stall_prev) begin
            chk("hold_valid", 32'(m_valid), 32'd1);
            chk("hold_data", 32'(m_data), 32'(held_data));
        end
        stall_prev = m_valid && !m_ready && !rst;
        held_data  = m_data;
        if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (m_valid && m_ready) begin
            pop_cnt++;
            chk("pop_has_data", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("m_data", 32'(m_data), 32'(exp_q.pop_front()));
        end
        last_acc = s_valid && s_ready;
        if (last_acc) begin
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
            exp_q.push_back(s_data);
            acc_cnt++;
        end
        cyc++;
    endtask

    task automatic tick();
        sample();
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || level != 7'd0) && n < 300) begin
            tick();
            n++;
        end
        chk({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_level0"}, 32'(level), 32'd0);
    endtask

    initial begin
        int nb;
        int acc0;
        rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; m_ready = 1'b0;
        @(negedge clk);

        // Reset state
        sample();
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        @(negedge clk);
        tick();
        rst = 1'b0;
        sample();
        chk("post_rst_s_ready", 32'(s_ready), 32'd1);
        chk("post_rst_m_valid", 32'(m_valid), 32'd0);
        chk("post_rst_m_data", 32'(m_data), 32'd0);
        chk("post_rst_level", 32'(level), 32'd0);
        chk("post_rst_we_en", 32'(ram_we_en), 32'd0);
        chk("post_rst_rd_en", 32'(ram_rd_en), 32'd0);
        chk("post_rst_we_addr", 32'(ram_we_addr), 32'd0);
        chk("post_rst_re_addr", 32'(ram_re_addr), 32'd0);
        @(negedge clk);

        // 5 bytes with m_ready high: order and 3-cycle fall-through
        m_ready = 1'b1;
        first_acc_cyc = -1; first_valid_cyc = -1;
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(8'h11 + i);
            sample();
            if (i == 0) begin
                chk("first_we_en", 32'(ram_we_en), 32'd1);
                chk("first_we_addr", 32'(ram_we_addr), 32'd0);
                chk("first_din", 32'(ram_din), 32'h11);
            end
            @(negedge clk);
        end
        s_valid = 1'b0;
        drain("t1");
        chk("t1_latency", 32'(first_valid_cyc - first_acc_cyc), 32'd3);

        // Fill to 65 with m_ready low, then drain
        m_ready = 1'b0;
        nb = 0;
        for (int i = 0; i < 80; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(nb);
            tick();
            if (last_acc) nb++;
        end
        s_valid = 1'b0;
        chk("t2_accepted", 32'(nb), 32'd65);
        chk("t2_full_s_ready", 32'(s_ready), 32'd0);
        chk("t2_level", 32'(level), 32'd65);
        m_ready = 1'b1;
        sample();
        chk("t2_rd_at_full", 32'(ram_rd_en), 32'd1);
        chk("t2_still_full", 32'(s_ready), 32'd0);
        @(negedge clk);
        sample();
        chk("t2_ready_rises", 32'(s_ready), 32'd1);
        @(negedge clk);
        drain("t2");

        // 200-byte stream: pointer wrap and 1 byte/cycle
        m_ready = 1'b1;
        acc0 = acc_cnt;
        pop_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(i * 7 + 3);
            tick();
        end
        s_valid = 1'b0;
        chk("t3_accepted", 32'(acc_cnt - acc0), 32'd200);
        chk("t3_pops", 32'(pop_cnt), 32'd197);
        drain("t3");

        // m_ready toggling: data held across stalls
        for (int i = 0; i < 60; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(8'hC0 + i);
            m_ready = (i % 2) == 1;
            tick();
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        drain("t4");

        // Reset mid-stream at level 10
        m_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(8'h30 + i);
            tick();
        end
        s_valid = 1'b0;
        tick();
        tick();
        chk("t5_level10", 32'(level), 32'd10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        sample();
        chk("t5_m_valid", 32'(m_valid), 32'd0);
        chk("t5_level", 32'(level), 32'd0);
        chk("t5_s_ready", 32'(s_ready), 32'd1);
        @(negedge clk);
        m_ready = 1'b1;
        pop_cnt = 0;
        s_valid = 1'b1;
        s_data  = 8'hA5;
        tick();
        s_valid = 1'b0;
        drain("t5");
        chk("t5_one_out", 32'(pop_cnt), 32'd1);

`ifdef FIFO_CTRL_STATS_EN
        // Drop counter: 5 then saturating at 255
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        chk("t6_drop_rst", 32'(drop_cnt), 32'd0);
        m_ready = 1'b0;
        nb = 0;
        for (int i = 0; i < 200 && nb < 65; i++) begin
            s_valid = s_ready;
            s_data  = 8'(nb);
            tick();
            if (last_acc) nb++;
        end
        chk("t6_filled", 32'(nb), 32'd65);
        chk("t6_drop_none", 32'(drop_cnt), 32'd0);
        s_valid = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        s_valid = 1'b0;
        chk("t6_drop5", 32'(drop_cnt), 32'd5);
        s_valid = 1'b1;
        for (int i = 0; i < 300; i++) tick();
        s_valid = 1'b0;
        chk("t6_drop_sat", 32'(drop_cnt), 32'd255);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
